// File: rtl/bus_mem_responder.sv
// bus_mem_responder: tiny16 bus memory responder with RAM clear FSM and two IO words.
//   clk, rst (async active-low)
//   bus_in, mem_addr_en, mem_in_en, mem_out_en : controller request strobes and bus value
//   bus_out, bus_out_en : registered read data and valid
//   busy : RAM clear in progress, requests ignored
//   io_out, io_out_strobe : output port register and write pulse
//   io_in : external input word
module bus_mem_responder #(
  parameter int          ADDR_W      = 8,
  parameter logic [15:0] IO_OUT_ADDR = 16'hFFF0,
  parameter logic [15:0] IO_IN_ADDR  = 16'hFFF1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        mem_addr_en,
  input  logic        mem_in_en,
  input  logic        mem_out_en,
  output logic [15:0] bus_out,
  output logic        bus_out_en,
  output logic        busy,
  output logic [15:0] io_out,
  output logic        io_out_strobe,
  input  logic [15:0] io_in
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, IDLE} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, ram_idx;
  logic [15:0] addr_q, addr_d, bus_out_q, bus_out_d, io_out_q, io_out_d, rd_data, ram_wd;
  logic bus_out_en_q, bus_out_en_d, strobe_q, strobe_d;
  logic idle, in_range, wr, ram_we;
  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      addr_q       <= '0;
      bus_out_q    <= '0;
      bus_out_en_q <= 1'b0;
      io_out_q     <= '0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      bus_out_q    <= bus_out_d;
      bus_out_en_q <= bus_out_en_d;
      io_out_q     <= io_out_d;
      strobe_q     <= strobe_d;
    end
  end

  always_comb begin
    state_d = (state_q == CLEAR && &cnt_q) ? IDLE : state_q;
    cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
  end

  // The bus carries one value per cycle, so an address latch wins over a write.
  always_comb begin
    idle         = state_q == IDLE;
    busy         = !idle;
    in_range     = 32'(addr_q) < DEPTH;
    wr           = idle && mem_in_en && !mem_addr_en;
    rd_data      = (addr_q == IO_OUT_ADDR) ? io_out_q :
                   (addr_q == IO_IN_ADDR)  ? io_in :
                   in_range ? mem[addr_q[ADDR_W-1:0]] : 16'h0000;
    addr_d       = (idle && mem_addr_en) ? bus_in : addr_q;
    bus_out_en_d = idle && mem_out_en;
    bus_out_d    = bus_out_en_d ? rd_data : 16'h0000;
    strobe_d     = wr && addr_q == IO_OUT_ADDR;
    io_out_d     = strobe_d ? bus_in : io_out_q;
    ram_we       = !idle || (wr && in_range);
    ram_idx      = idle ? addr_q[ADDR_W-1:0] : cnt_q;
    ram_wd       = idle ? bus_in : 16'h0000;
  end

  // RAM has no reset; the clear sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= ram_wd;
  end

  assign bus_out       = bus_out_q;
  assign bus_out_en    = bus_out_en_q;
  assign io_out        = io_out_q;
  assign io_out_strobe = strobe_q;
endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder on the tiny16 CPU bus. Answers the controller's mem_addr_en, mem_out_en and mem_in_en strobes.
- Contains a word-addressed RAM, a 16-bit address latch, a registered read path, a write path, and two memory-mapped IO words.
- After reset, a clear FSM zeroes the RAM before the block serves any request.
- Samples on posedge clk. The controller drives its strobes on negedge, so the half-cycle offset is intentional.

Parameters:
- ADDR_W, 8, RAM index width; DEPTH = 2**ADDR_W words of 16 bits.
- IO_OUT_ADDR, 16'hFFF0, bus address of the output port register (read/write).
- IO_IN_ADDR, 16'hFFF1, bus address of the input port (read-only).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- bus_in  input  16  bus value; carries the address when mem_addr_en is high and write data when mem_in_en is high.
- mem_addr_en  input  1  latch bus_in into the address register.
- mem_in_en  input  1  write bus_in to the latched address.
- mem_out_en  input  1  read from the latched address onto bus_out.
- bus_out  output  16  read data.
- bus_out_en  output  1  bus_out is valid and driving.
- busy  output  1  clear in progress; requests ignored.
- io_out  output  16  output port register.
- io_out_strobe  output  1  one-cycle pulse on each write to IO_OUT_ADDR.
- io_in  input  16  external input word.

Behaviour:
- Reset (rst low, async):
  - addr=0, bus_out=0, bus_out_en=0, io_out=0, io_out_strobe=0.
  - busy=1, FSM=CLEAR, clear counter=0.
  - RAM contents are not reset directly; the clear FSM zeroes them.
- FSM CLEAR:
  - Each posedge writes 0 to RAM[counter], then counter+1.
  - After writing index DEPTH-1, go to IDLE and set busy=0 on the same edge.
  - Duration is exactly DEPTH cycles after rst rises.
  - All strobes are ignored: no address latch, no write, bus_out_en stays 0.
- FSM IDLE: serves requests at every posedge.
- Address latch:
  - mem_addr_en=1: addr <= bus_in (full 16 bits).
  - In RAM range when addr < DEPTH; index = addr[ADDR_W-1:0].
- Read:
  - mem_out_en=1: bus_out <= selected data and bus_out_en <= 1 on the same edge.
  - Otherwise bus_out_en <= 0 and bus_out <= 0.
  - Latency is one posedge. Data is valid at the following negedge, when the controller samples it.
  - Read selection: IO_OUT_ADDR returns io_out; IO_IN_ADDR returns io_in, sampled at that edge; in-range returns RAM[index]; anything else returns 16'h0000.
- Write:
  - mem_in_en=1: in-range writes RAM[index] <= bus_in.
  - IO_OUT_ADDR: io_out <= bus_in and io_out_strobe <= 1 for one cycle.
  - IO_IN_ADDR and out-of-range addresses: write dropped.
  - io_out_strobe is 0 in every other cycle.
- Simultaneous events:
  - mem_addr_en together with mem_in_en: address latches, write is suppressed, because the bus carries only one value.
  - mem_addr_en together with mem_out_en: read uses the old addr.
  - mem_out_en together with mem_in_en at the same address: read returns the pre-write value, then the write commits.
  - Back-to-back mem_out_en cycles: data is re-read each cycle; bus_out_en stays high.
- Address wrap: none. addr is 16 bits; values >= DEPTH other than the IO addresses are out of range.
- Reset mid-clear or mid-operation:
  - Outputs return to reset values immediately.
  - The clear restarts from index 0.
  - A pending read is dropped (bus_out_en=0).

Test Plan:
- Clear and busy: release rst with DEPTH=256 -> busy=1 for exactly 256 posedges, then 0; a read of addr 8'h7F afterwards returns 16'h0000.
- Write then read:
  - Cycle 1: mem_addr_en with bus_in=16'h0010.
  - Cycle 2: mem_in_en with bus_in=16'hBEEF.
  - Cycle 3: mem_out_en.
  - Required: bus_out=16'hBEEF with bus_out_en=1 one posedge after mem_out_en; bus_out_en=0 the next cycle.
- IO ports:
  - Write 16'h1234 to 16'hFFF0 -> io_out=16'h1234 and one io_out_strobe pulse; a read of FFF0 returns 16'h1234.
  - With io_in=16'hA5A5, a read of FFF1 returns 16'hA5A5.
  - A write to FFF1 changes nothing.
- Out of range: write 16'h5555 to 16'h0100 (DEPTH=256), then read it -> 16'h0000; RAM[0x00] is unchanged.
- Simultaneous strobes:
  - mem_addr_en with mem_in_en -> no write occurs.
  - mem_out_en with mem_in_en at addr 3 holding 16'h0001 and bus_in=16'h0002 -> bus_out=16'h0001; the next read returns 16'h0002.
- Reset mid-clear: assert rst at clear index 100, release it -> busy=1 for a full 256 cycles again, and bus_out_en=0 throughout.
